// File: rtl/sap_core_if.sv
// Purpose: bundles the program-load, control and result signals of sap_core.
// Latency: none; plain wires between testbench/host (master) and core (slave).
// Backpressure: none; the host paces the core through step_en and prog_mode.
// Ports: step_en/prog_mode/prog_we/prog_addr/prog_data host->core;
//        out_data/out_valid/halted/flags core->host.
interface sap_core_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              step_en;
    logic              prog_mode;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_data;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              halted;
    logic [1:0]        flags;

    modport master (
        output step_en, prog_mode, prog_we, prog_addr, prog_data,
        input  out_data, out_valid, halted, flags
    );

    modport slave (
        input  step_en, prog_mode, prog_we, prog_addr, prog_data,
        output out_data, out_valid, halted, flags
    );
endinterface

// File: rtl/sap_core.sv
// Purpose: SAP-1 style accumulator CPU with on-chip RAM, loadable in prog_mode.
// Latency: 3 to 5 enabled microsteps per instruction (fetch is T0/T1).
// Backpressure: none; the core advances only on fastClk edges with step_en high.
// Ports: fastClk (sole clock), rst (async, active-high), bus (sap_core_if.slave):
//        program load strobes in, out_data/out_valid/halted/flags{carry,zero} out.
module sap_core #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic       fastClk,
    input  logic       rst,
    sap_core_if.slave  bus
);
    localparam logic [2:0] T0 = 3'd0;
    localparam logic [2:0] T1 = 3'd1;
    localparam logic [2:0] T2 = 3'd2;
    localparam logic [2:0] T3 = 3'd3;
    localparam logic [2:0] T4 = 3'd4;

    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // Program/data RAM; deliberately outside the reset domain so rst keeps the program.
    logic [DATA_W-1:0] mem [2**ADDR_W];

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] mar;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [2:0]        tstep;
    logic              carry;
    logic              zero;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              halted;

    logic [3:0]        opcode;
    logic [ADDR_W-1:0] operand;
    logic [DATA_W-1:0] ram_rd;
    logic              run_step;

    assign opcode   = ir[DATA_W-1 -: 4];
    assign operand  = ir[ADDR_W-1:0];
    assign ram_rd   = mem[mar];
    assign run_step = bus.step_en && !bus.prog_mode && !halted;

    // ALU: subtraction is A + ~B + 1, so the carry-out doubles as "no borrow".
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W:0]   alu_sum;
    always_comb begin
        alu_b   = (opcode == OP_SUB) ? ~b : b;
        alu_sum = {1'b0, a} + {1'b0, alu_b} + {{DATA_W{1'b0}}, (opcode == OP_SUB)};
    end

    // RAM write port shared by program load and STA T3.
    logic              ram_we;
    logic [ADDR_W-1:0] ram_wa;
    logic [DATA_W-1:0] ram_wd;
    always_comb begin
        ram_we = 1'b0;
        ram_wa = mar;
        ram_wd = a;
        if (bus.prog_mode) begin
            ram_we = bus.prog_we;
            ram_wa = bus.prog_addr;
            ram_wd = bus.prog_data;
        end else if (run_step && tstep == T3 && opcode == OP_STA) begin
            ram_we = 1'b1;
        end
    end

    always_ff @(posedge fastClk) begin
        if (ram_we) begin
            mem[ram_wa] <= ram_wd;
        end
    end

    always_ff @(posedge fastClk or posedge rst) begin
        if (rst) begin
            pc        <= '0;
            mar       <= '0;
            ir        <= '0;
            a         <= '0;
            b         <= '0;
            tstep     <= T0;
            carry     <= 1'b0;
            zero      <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            halted    <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (bus.prog_mode) begin
                // Abort anything in flight; A, B, IR and out_data are kept.
                pc     <= '0;
                mar    <= '0;
                tstep  <= T0;
                halted <= 1'b0;
                carry  <= 1'b0;
                zero   <= 1'b0;
            end else if (run_step) begin
                case (tstep)
                    T0: begin
                        mar   <= pc;
                        tstep <= T1;
                    end
                    T1: begin
                        ir    <= ram_rd;
                        pc    <= pc + 1'b1;
                        tstep <= T2;
                    end
                    T2: begin
                        tstep <= T0;
                        case (opcode)
                            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                                mar   <= operand;
                                tstep <= T3;
                            end
                            OP_LDI: a <= {{(DATA_W-ADDR_W){1'b0}}, operand};
                            OP_JMP: pc <= operand;
                            OP_JC:  if (carry) pc <= operand;
                            OP_JZ:  if (zero) pc <= operand;
                            OP_OUT: begin
                                out_data  <= a;
                                out_valid <= 1'b1;
                            end
                            OP_HLT: halted <= 1'b1;
                            default: ;
                        endcase
                    end
                    T3: begin
                        tstep <= T0;
                        case (opcode)
                            OP_LDA: a <= ram_rd;
                            OP_ADD, OP_SUB: begin
                                b     <= ram_rd;
                                tstep <= T4;
                            end
                            default: ;
                        endcase
                    end
                    T4: begin
                        // Only ADD/SUB reach T4.
                        a     <= alu_sum[DATA_W-1:0];
                        carry <= alu_sum[DATA_W];
                        zero  <= (alu_sum[DATA_W-1:0] == '0);
                        tstep <= T0;
                    end
                    default: tstep <= T0;
                endcase
            end
        end
    end

    assign bus.out_data  = out_data;
    assign bus.out_valid = out_valid;
    assign bus.halted    = halted;
    assign bus.flags     = {carry, zero};
endmodule
